// File: rtl/grocery_pkg.sv
// Shared encodings and default widths for the grocery checkout controller.
package grocery_pkg;

    // Default datapath widths.
    localparam int PW_DEFAULT = 4;
    localparam int TW_DEFAULT = 8;
    localparam int CW_DEFAULT = 6;

    // Per-lane operation encoding.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Controller states: IDLE arbitrates, EXEC applies the latched item.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts at ptr+1 and wraps,
// so the lane at ptr (the last one served) has the lowest priority.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [IW-1:0]    win_idx,
    output logic             any_valid
);

    int          cand;
    logic [IW-1:0] cand_idx;

    // Scan lanes in priority order; the first requester found wins.
    always_comb begin
        win_oh    = '0;
        win_idx   = '0;
        any_valid = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand     = (int'(ptr) + k) % N_REQ;
            cand_idx = IW'(cand);
            if (!any_valid && req[cand_idx]) begin
                any_valid        = 1'b1;
                win_idx          = cand_idx;
                win_oh[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/grocery_checkout_ctrl.sv
// Checkout controller: round-robin shares one saturating running-total
// accumulator between scanner lanes, one item per two-cycle transaction.
// Handshake: a lane raises req with op/price stable and holds it until it
// sees a one-cycle gnt; gnt marks the item consumed (even when a clear in
// the same cycle discards its effect on the total).
module grocery_checkout_ctrl
    import grocery_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = PW_DEFAULT,
    parameter int TW    = TW_DEFAULT,
    parameter int CW    = CW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ-1:0]  op,
    input  logic [N_REQ*PW-1:0] price,
    input  logic              clear,
    output logic [N_REQ-1:0]  gnt,
    output logic [TW-1:0]     total,
    output logic [CW-1:0]     item_cnt,
    output logic              ovf,
    output logic              unf,
    output logic              busy
);

    localparam int IW = $clog2(N_REQ);
    localparam logic [TW-1:0] TOT_MAX = {TW{1'b1}};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            op_q, op_d;
    logic [PW-1:0]   price_q, price_d;
    logic [TW-1:0]   total_q, total_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d;

    logic [N_REQ-1:0] win_oh;
    logic [IW-1:0]    win_idx;
    logic             any_valid;
    logic             win_op;
    logic [PW-1:0]    win_price;
    logic [TW:0]      sum;
    logic [TW-1:0]    price_ext;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .win_oh    (win_oh),
        .win_idx   (win_idx),
        .any_valid (any_valid)
    );

    // One extra bit on the sum exposes an add that would exceed TOT_MAX.
    assign price_ext = {{(TW-PW){1'b0}}, price_q};
    assign sum       = {1'b0, total_q} + {1'b0, price_ext};

    // Route the winning lane's op and price using the one-hot grant.
    always_comb begin
        win_op    = |(op & win_oh);
        win_price = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_oh[i]) win_price = win_price | price[i*PW +: PW];
        end
    end

    // Next-state, latch and accumulator update; clear overrides the update.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        op_d    = op_q;
        price_d = price_q;
        total_d = total_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        gnt_d   = '0;
        busy_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    state_d = ST_EXEC;
                    idx_d   = win_idx;
                    op_d    = win_op;
                    price_d = win_price;
                    busy_d  = 1'b1;
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                gnt_d   = N_REQ'(1) << idx_q;
                ptr_d   = idx_q;
                if (op_q == OP_SUB) begin
                    if (price_ext > total_q) begin
                        total_d = '0;
                        unf_d   = 1'b1;
                    end else begin
                        total_d = total_q - price_ext;
                    end
                    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                end else begin
                    if (sum[TW]) begin
                        total_d = TOT_MAX;
                        ovf_d   = 1'b1;
                    end else begin
                        total_d = sum[TW-1:0];
                    end
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear) begin
            total_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end
    end

    // State and output registers; pointer resets to the last lane so lane 0 leads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= IW'(N_REQ - 1);
            idx_q   <= '0;
            op_q    <= 1'b0;
            price_q <= '0;
            total_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            price_q <= price_d;
            total_q <= total_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt      = gnt_q;
    assign total    = total_q;
    assign item_cnt = cnt_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_grocery_checkout_ctrl.sv
// Bench for grocery_checkout_ctrl: directed scenarios plus random lane traffic,
// checked against an integer reference model through an expected-response queue.
module tb_grocery_checkout_ctrl;

    localparam int N    = 4;
    localparam int PW   = 4;
    localparam int TW   = 8;
    localparam int CW   = 6;
    localparam int TMAX = (1 << TW) - 1;
    localparam int CMAX = (1 << CW) - 1;
    localparam int EW   = N + TW + CW + 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req;
    logic [N-1:0]    op;
    logic [N*PW-1:0] price;
    logic            clear;
    logic [N-1:0]    gnt;
    logic [TW-1:0]   total;
    logic [CW-1:0]   item_cnt;
    logic            ovf;
    logic            unf;
    logic            busy;

    grocery_checkout_ctrl #(.N_REQ(N), .PW(PW), .TW(TW), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst_n),
        .req      (req),
        .op       (op),
        .price    (price),
        .clear    (clear),
        .gnt      (gnt),
        .total    (total),
        .item_cnt (item_cnt),
        .ovf      (ovf),
        .unf      (unf),
        .busy     (busy)
    );

    // ---------------- counters / scoreboard ----------------
    int n_chk  = 0;
    int n_pass = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [EW-1:0] pack(input logic [N-1:0] g, input int t, input int c,
                                           input bit o, input bit u);
        logic [TW-1:0] tt;
        logic [CW-1:0] cc;
        tt = TW'(t);
        cc = CW'(c);
        return {g, tt, cc, o, u};
    endfunction

    // ---------------- reference model ----------------
    // One pending item at a time: chosen when the model is free, applied on
    // the following edge; clear wipes the basket on any edge it is seen.
    int m_tot, m_cnt, m_ptr, m_lane, m_price, m_j;
    bit m_ovf, m_unf, m_pend, m_op, m_found;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tot = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
            m_pend = 0; m_ptr = N - 1; m_lane = 0; m_op = 0; m_price = 0;
            exp_q.delete();
        end else if (m_pend) begin
            if (clear) begin
                m_tot = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
            end else if (!m_op) begin
                if (m_tot + m_price > TMAX) begin m_tot = TMAX; m_ovf = 1; end
                else m_tot = m_tot + m_price;
                if (m_cnt < CMAX) m_cnt = m_cnt + 1;
            end else begin
                if (m_price > m_tot) begin m_tot = 0; m_unf = 1; end
                else m_tot = m_tot - m_price;
                if (m_cnt > 0) m_cnt = m_cnt - 1;
            end
            m_ptr  = m_lane;
            m_pend = 0;
            exp_q.push_back(pack(N'(1) << m_lane, m_tot, m_cnt, m_ovf, m_unf));
        end else begin
            if (clear) begin
                m_tot = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
            end
            m_found = 0;
            for (int k = 1; k <= N; k++) begin
                m_j = (m_ptr + k) % N;
                if (!m_found && req[m_j]) begin
                    m_found = 1;
                    m_lane  = m_j;
                    m_op    = op[m_j];
                    m_price = int'(price[m_j*PW +: PW]);
                end
            end
            m_pend = m_found;
        end
    end

    // ---------------- monitor ----------------
    logic [EW-1:0] mon_exp;
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", 32'(busy), 32'(m_pend));
            check("status", 32'({total, item_cnt, ovf, unf}),
                  32'(pack('0, m_tot, m_cnt, m_ovf, m_unf)));
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check("grant", 32'({gnt, total, item_cnt, ovf, unf}), 32'(mon_exp));
            end else begin
                check("no_gnt", 32'(gnt), 32'd0);
            end
        end
    end

    // ---------------- driver ----------------
    int         left[N];
    bit         lop[N];
    logic [PW-1:0] lprice[N];
    bit         rand_en = 0;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i]             = (left[i] != 0);
            op[i]              = lop[i];
            price[i*PW +: PW]  = lprice[i];
        end
    endtask

    // Advance to the next falling edge and react to grants seen there.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (gnt[i] && left[i] > 0) begin
                left[i]--;
                if (left[i] > 0 && rand_en) begin
                    lop[i]    = 1'($urandom_range(0, 1));
                    lprice[i] = PW'($urandom_range(0, 15));
                end
            end else if (rand_en && left[i] == 0 && $urandom_range(0, 3) == 0) begin
                left[i]   = $urandom_range(1, 3);
                lop[i]    = 1'($urandom_range(0, 1));
                lprice[i] = PW'($urandom_range(0, 15));
            end
        end
        clear = rand_en && ($urandom_range(0, 15) == 0);
        drive();
    endtask

    function automatic bit lanes_idle();
        for (int i = 0; i < N; i++) if (left[i] != 0) return 0;
        return 1;
    endfunction

    task automatic wait_idle(input int budget);
        bit done;
        done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            tick();
            if (lanes_idle() && !busy && exp_q.size() == 0) done = 1;
        end
        if (!done) begin
            n_chk++;
            $display("FAIL wait_idle: timeout after %0d cycles", budget);
        end
    endtask

    task automatic send_item(input int lane, input bit o, input int p);
        lop[lane]    = o;
        lprice[lane] = PW'(p);
        left[lane]   = 1;
        wait_idle(40);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin left[i] = 0; lop[i] = 0; lprice[i] = '0; end
        clear = 1'b0;
        drive();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [N-1:0] glog[$];
    logic [N-1:0] fair_exp[5];
    logic [N-1:0] first_g;
    bit           seen;

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        for (int i = 0; i < N; i++) begin left[i] = 0; lop[i] = 0; lprice[i] = '0; end
        drive();
        repeat (2) @(negedge clk);
        check("rst_total", 32'(total), 32'd0);
        check("rst_cnt", 32'(item_cnt), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_unf", 32'(unf), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Single request from lane 0.
        send_item(0, 0, 5);
        check("single_total", 32'(total), 32'd5);
        check("single_cnt", 32'(item_cnt), 32'd1);

        // Round-robin fairness with all lanes requesting.
        do_reset();
        fair_exp[0] = 4'b0001; fair_exp[1] = 4'b0010; fair_exp[2] = 4'b0100;
        fair_exp[3] = 4'b1000; fair_exp[4] = 4'b0001;
        for (int i = 0; i < N; i++) begin lop[i] = 0; lprice[i] = 1; left[i] = 1; end
        left[0] = 2;
        glog.delete();
        for (int c = 0; c < 40 && glog.size() < 5; c++) begin
            tick();
            if (gnt != 0) glog.push_back(gnt);
        end
        check("fair_count", 32'(glog.size()), 32'd5);
        for (int i = 0; i < 5 && i < glog.size(); i++) check("fair_order", 32'(glog[i]), 32'(fair_exp[i]));
        wait_idle(20);
        check("fair_total", 32'(total), 32'd5);

        // Saturating add.
        do_reset();
        for (int i = 0; i < 16; i++) send_item(1, 0, 15);
        send_item(1, 0, 10);
        check("pre_sat_total", 32'(total), 32'd250);
        send_item(2, 0, 9);
        check("sat_total", 32'(total), 32'd255);
        check("sat_ovf", 32'(ovf), 32'd1);
        check("sat_cnt", 32'(item_cnt), 32'd18);

        // Subtract clamped at zero.
        do_reset();
        send_item(3, 0, 2);
        send_item(3, 1, 3);
        check("unf_total", 32'(total), 32'd0);
        check("unf_flag", 32'(unf), 32'd1);
        check("unf_cnt", 32'(item_cnt), 32'd0);

        // Clear colliding with an EXEC cycle.
        do_reset();
        send_item(1, 0, 3);
        lop[2] = 0; lprice[2] = 7; left[2] = 1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (busy) seen = 1;
        end
        check("clr_busy_seen", 32'(seen), 32'd1);
        clear = 1'b1;
        tick();
        check("clr_gnt", 32'(gnt), 32'b0100);
        check("clr_total", 32'(total), 32'd0);
        check("clr_cnt", 32'(item_cnt), 32'd0);
        check("clr_flags", 32'({ovf, unf}), 32'd0);
        wait_idle(20);

        // Asynchronous reset while EXEC is in progress.
        do_reset();
        send_item(1, 0, 6);
        left[2] = 1; left[3] = 1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (busy) seen = 1;
        end
        check("ar_busy_seen", 32'(seen), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_gnt", 32'(gnt), 32'd0);
        check("ar_total", 32'(total), 32'd0);
        check("ar_cnt", 32'(item_cnt), 32'd0);
        for (int i = 0; i < N; i++) begin left[i] = 1; lop[i] = 0; lprice[i] = 2; end
        tick();
        rst_n = 1'b1;
        first_g = '0;
        for (int c = 0; c < 10 && first_g == 0; c++) begin
            tick();
            if (gnt != 0) first_g = gnt;
        end
        check("ar_first_gnt", 32'(first_g), 32'b0001);
        wait_idle(40);

        // Random traffic with occasional clears.
        do_reset();
        rand_en = 1;
        repeat (1500) tick();
        rand_en = 0;
        wait_idle(200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/grocery_checkout_ctrl.md
Name: grocery_checkout_ctrl

Overview:
Checkout controller that shares one running-total accumulator (add/subtract of item prices) between several scanner lanes.
- Round-robin arbitration among requesting lanes; one granted item per transaction.
- Saturating arithmetic on the total, plus an item count and sticky overflow/underflow flags.
- Sits between the debounced lane inputs and the display/total register of the grocery calculator datapath.

Parameters:
N_REQ, 4, number of requesting scanner lanes (2..8)
PW, 4, price width per lane in bits
TW, 8, running-total width in bits (TW > PW)
CW, 6, item-count width in bits

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
req  in  N_REQ  per-lane request, level; lane holds high until granted
op  in  N_REQ  per-lane operation, 0 = add, 1 = subtract; sampled with price
price  in  N_REQ*PW  lane i price at bits [i*PW +: PW]
clear  in  1  synchronous session clear, single-cycle pulse
gnt  out  N_REQ  one-hot grant pulse, one cycle, marks the item consumed
total  out  TW  running total
item_cnt  out  CW  items currently in the basket
ovf  out  1  sticky flag: an add saturated
unf  out  1  sticky flag: a subtract clamped at zero
busy  out  1  high while in EXEC

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, total=0, item_cnt=0, ovf=0, unf=0, gnt=0, busy=0, RR pointer=N_REQ-1 so lane 0 has top priority.
- FSM has 2 states: IDLE and EXEC.
- IDLE:
  - If any req bit is high, pick the winner round-robin, searching from pointer+1 upward with wrap.
  - Latch the winner's index, op and price; go to EXEC.
  - If no req is high, stay in IDLE.
- EXEC:
  - Apply the latched op to total and item_cnt.
  - Drive gnt[idx]=1 for exactly this cycle; set busy=1.
  - Set pointer=idx; return to IDLE.
- Latency: req high at edge k (IDLE) -> gnt and updated total visible after edge k+1 -> next arbitration at edge k+2. Peak throughput is 1 item per 2 cycles.
- A lane holding req high across its own gnt is treated as requesting a new item. It re-enters arbitration at the lowest priority.
- req dropped while in EXEC: the item latched in IDLE is still applied and granted.
- Add:
  - total = min(total + zero-extended price, 2^TW-1).
  - Saturation sets ovf.
  - item_cnt += 1, saturating at 2^CW-1.
- Subtract:
  - If price > total: total = 0 and unf is set.
  - Otherwise total -= price.
  - item_cnt -= 1, floor 0.
- price = 0 is legal and still counts as an item.
- clear:
  - Next edge: total=0, item_cnt=0, ovf=0, unf=0.
  - clear takes priority over an EXEC update in the same cycle. The item is discarded, but gnt still pulses so the lane is released.
  - State and pointer are unaffected by clear.
- Reset asserted mid-EXEC: gnt drops immediately (asynchronous) and no update occurs.
- All outputs are registered; no combinational path from req to gnt.

Decomposition:
- Shared package grocery_pkg holds:
  - op encodings OP_ADD=1'b0, OP_SUB=1'b1
  - state encodings ST_IDLE, ST_EXEC
  - default widths PW/TW/CW
- One natural sub-module: rr_arbiter.
  - Inputs: req vector and pointer.
  - Outputs: one-hot winner, winner index, any-valid.
  - Combinational core only; the pointer register stays in grocery_checkout_ctrl.

Test Plan:
- Reset then single request: req=0001, op=0, price=5 -> gnt=0001 one cycle later, total=5, item_cnt=1, two cycles per item.
- Round-robin fairness: req=1111 held, all prices=1 -> grants in order 0001,0010,0100,1000,0001; total=5 after 5 grants.
- Saturation: total=250, add 9 -> total=255, ovf=1. Subtract 3 from total=2 -> total=0, unf=1, item_cnt decremented.
- Clear collision: clear pulsed in the same cycle as EXEC of an add of 7 -> total=0, item_cnt=0, flags 0, gnt still pulses for that lane.
- Async reset mid-EXEC: drive rst=0 between edges while busy=1 -> gnt/busy drop immediately, total=0; the next grant after release goes to lane 0.
